// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake/data bundle for the sequential ALU.
//   master : drives start, A, B, sel; observes C, flags, err, busy, done
//   slave  : the ALU side (reverse directions)
// Signals:
//   start        request, sampled by the ALU only while idle
//   A, B         operands (B is also the shift amount)
//   sel          4-bit opcode
//   C            registered result
//   flags        {V,N,Cy,Z}, registered together with C
//   err          last operation used an illegal opcode
//   busy         multi-cycle operation in progress
//   done         one-cycle pulse when C/flags/err update
`timescale 1ns/1ps
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic [WIDTH-1:0] C;
    logic [3:0]       flags;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, sel,
        input  C, flags, err, busy, done
    );

    modport slave (
        input  start, A, B, sel,
        output C, flags, err, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/done handshake and registered result/flags.
// Single-cycle ops: ADD, SUB, AND, OR, XOR, CMP (and illegal opcodes).
// SHL/SHR shift one bit per cycle under a down-counter; the optional
// multiply (macro ALU_SEQ_MUL_EN) is a WIDTH-step shift-add.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave (start, A, B, sel -> C, flags, err, busy, done)
// Parameter WIDTH: operand/result width, must be at least 4.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; single-cycle results written on accept
// SHIFT  | one bit per cycle, counter counts down to terminal count
// MUL    | one partial product per cycle (only with ALU_SEQ_MUL_EN)
// DONE   | C/flags/err just updated, done=1, start ignored
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH + 1);

    localparam logic [SHW-1:0]   CNT_FULL = SHW'(WIDTH);
    localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH:0]   mul_sum;
`endif

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_v;
    logic             sub_v;
    logic [WIDTH-1:0] cmp_res;
    logic [SHW-1:0]   shamt;
    logic             tc;
    logic             sh_left;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic v,
                                            input logic cy);
        return {v, r[WIDTH-1], cy, (r == '0)};
    endfunction

    assign accept = (state_q == S_IDLE) && bus.start;

    // The extra MSB of the difference is the unsigned borrow.
    assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_full = {1'b0, bus.A} - {1'b0, bus.B};
    assign add_v    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                      (add_full[WIDTH-1] != bus.A[WIDTH-1]);
    assign sub_v    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                      (sub_full[WIDTH-1] != bus.A[WIDTH-1]);

    always_comb begin
        cmp_res    = '0;
        cmp_res[1] = (bus.A == bus.B);
        cmp_res[0] = (bus.A > bus.B);
    end

    // Shifting WIDTH or more places always clears the word, so clamp.
    assign shamt   = (bus.B >= WIDTH_V) ? CNT_FULL : SHW'(bus.B);
    assign tc      = (cnt_q == CNT_ONE);
    assign sh_left = (op_q == OP_SHL);
    assign sh_next = sh_left ? {w_q[WIDTH-2:0], 1'b0} : {1'b0, w_q[WIDTH-1:1]};
    assign sh_out  = sh_left ? w_q[WIDTH-1] : w_q[0];

`ifdef ALU_SEQ_MUL_EN
    // Product lives in {hi_q, w_q}; multiplier bits are consumed from w_q[0].
    assign mul_sum = {1'b0, hi_q} + (w_q[0] ? {1'b0, a_q} : '0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.sel)
                        OP_SHL, OP_SHR: state_d = (shamt == '0) ? S_DONE : S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL:         state_d = S_MUL;
`endif
                        default:        state_d = S_DONE;
                    endcase
                end
            end
            S_SHIFT: if (tc) state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:   if (tc) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state_q == S_SHIFT) || (state_q == S_MUL);
        bus.done = (state_q == S_DONE);
    end

    assign bus.C     = c_q;
    assign bus.flags = flags_q;
    assign bus.err   = err_q;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            w_q     <= '0;
            op_q    <= '0;
            c_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            a_q     <= '0;
            hi_q    <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            op_q    <= op_d;
            c_q     <= c_d;
            flags_q <= flags_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            a_q     <= a_d;
            hi_q    <= hi_d;
`endif
        end
    end

    // Datapath next values; C/flags/err only change on the edge entering DONE.
    always_comb begin
        cnt_d   = cnt_q;
        w_d     = w_q;
        op_d    = op_q;
        c_d     = c_q;
        flags_d = flags_q;
        err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
        a_d     = a_q;
        hi_d    = hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = bus.sel;
                    case (bus.sel)
                        OP_ADD: begin
                            c_d     = add_full[WIDTH-1:0];
                            flags_d = mk_flags(add_full[WIDTH-1:0], add_v, add_full[WIDTH]);
                            err_d   = 1'b0;
                        end
                        OP_SUB: begin
                            c_d     = sub_full[WIDTH-1:0];
                            flags_d = mk_flags(sub_full[WIDTH-1:0], sub_v, sub_full[WIDTH]);
                            err_d   = 1'b0;
                        end
                        OP_AND: begin
                            c_d     = bus.A & bus.B;
                            flags_d = mk_flags(bus.A & bus.B, 1'b0, 1'b0);
                            err_d   = 1'b0;
                        end
                        OP_OR: begin
                            c_d     = bus.A | bus.B;
                            flags_d = mk_flags(bus.A | bus.B, 1'b0, 1'b0);
                            err_d   = 1'b0;
                        end
                        OP_XOR: begin
                            c_d     = bus.A ^ bus.B;
                            flags_d = mk_flags(bus.A ^ bus.B, 1'b0, 1'b0);
                            err_d   = 1'b0;
                        end
                        OP_SHL, OP_SHR: begin
                            cnt_d = shamt;
                            w_d   = bus.A;
                            if (shamt == '0) begin
                                c_d     = bus.A;
                                flags_d = mk_flags(bus.A, 1'b0, 1'b0);
                                err_d   = 1'b0;
                            end
                        end
                        OP_CMP: begin
                            c_d     = cmp_res;
                            flags_d = mk_flags(cmp_res, 1'b0, 1'b0);
                            err_d   = 1'b0;
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            cnt_d = CNT_FULL;
                            a_d   = bus.A;
                            w_d   = bus.B;
                            hi_d  = '0;
                        end
`endif
                        default: begin
                            c_d     = '0;
                            flags_d = 4'b0001;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_ONE;
                w_d   = sh_next;
                if (tc) begin
                    c_d     = sh_next;
                    flags_d = mk_flags(sh_next, 1'b0, sh_out);
                    err_d   = 1'b0;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                cnt_d = cnt_q - CNT_ONE;
                hi_d  = mul_sum[WIDTH:1];
                w_d   = {mul_sum[0], w_q[WIDTH-1:1]};
                if (tc) begin
                    c_d     = {mul_sum[0], w_q[WIDTH-1:1]};
                    flags_d = mk_flags({mul_sum[0], w_q[WIDTH-1:1]}, 1'b0,
                                       |mul_sum[WIDTH:1]);
                    err_d   = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end
endmodule
